// File: rtl/reg_writeback.sv
// reg_writeback: commit stage for the register files.
//   Each unstalled cycle offers one commit slot. An ALU/FPU result wins
//   the slot; otherwise the oldest entry of a small load-result FIFO
//   commits. The chosen result is registered into an output stage that
//   drives the register-file write port one cycle later. The stage also
//   keeps integer and FP scoreboards of destinations with writes in flight.
// Ports:
//   CLK, RST_N                    clock, async active-low reset
//   Stall                         freeze commits and the output stage
//   issue_valid/_rd/_fp           mark a destination busy
//   alu_valid/_rd/_fp/_data       ALU result in, alu_ready out (accepted)
//   mem_valid/_rd/_fp/_data       load result in, mem_ready out (FIFO not full)
//   WE_reg, WE_freg               integer / FP write enables
//   rd_addr_ex, reg_write_data    write address / data
//   busy_int, busy_fp             pending-write masks
//   fifo_count                    load FIFO occupancy
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_fp,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic        alu_fp,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic        mem_fp,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        WE_reg,
  output logic        WE_freg,
  output logic [4:0]  rd_addr_ex,
  output logic [31:0] reg_write_data,
  output logic [31:0] busy_int,
  output logic [31:0] busy_fp,
  output logic [2:0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);

  // FIFO entry layout: {fp, rd[4:0], data[31:0]}
  logic [37:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;

  logic          push, pop, commit;
  logic          c_fp;
  logic [4:0]    c_rd;
  logic [31:0]   c_data;

  logic          we_reg_q, we_freg_q;
  logic [4:0]    rd_q;
  logic [31:0]   data_q;
  logic [31:0]   busy_int_q, busy_int_d;
  logic [31:0]   busy_fp_q, busy_fp_d;

  // ---------------------------------------------------------------
  // Commit arbitration: ALU first, FIFO head only when the ALU is idle.
  // ---------------------------------------------------------------
  assign mem_ready = (count_q != 3'(DEPTH));
  assign push      = mem_valid & mem_ready;
  assign alu_ready = alu_valid & ~Stall;
  assign pop       = ~Stall & ~alu_valid & (count_q != 3'd0);
  assign commit    = alu_ready | pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    c_fp   = fifo_mem[rd_ptr_q][37];
    c_rd   = fifo_mem[rd_ptr_q][36:32];
    c_data = fifo_mem[rd_ptr_q][31:0];
    if (alu_valid) begin
      c_fp   = alu_fp;
      c_rd   = alu_rd;
      c_data = alu_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------
  // Scoreboards: clear on commit, then set on issue so a same-cycle
  // set overrides the clear. x0 is never busy.
  // ---------------------------------------------------------------
  always_comb begin
    busy_int_d = busy_int_q;
    busy_fp_d  = busy_fp_q;
    if (commit) begin
      if (c_fp) busy_fp_d[c_rd]  = 1'b0;
      else      busy_int_d[c_rd] = 1'b0;
    end
    if (issue_valid) begin
      if (issue_fp) busy_fp_d[issue_rd]  = 1'b1;
      else          busy_int_d[issue_rd] = 1'b1;
    end
    busy_int_d[0] = 1'b0;
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which entries are live, so stale data is never read.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {mem_fp, mem_rd, mem_data};
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_int_q <= '0;
      busy_fp_q  <= '0;
      we_reg_q   <= 1'b0;
      we_freg_q  <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      busy_int_q <= busy_int_d;
      busy_fp_q  <= busy_fp_d;
      // A stall freezes the whole output stage, including a pending
      // enable, so that write lands once the stall releases.
      if (!Stall) begin
        we_reg_q  <= commit & ~c_fp & (c_rd != 5'd0);
        we_freg_q <= commit & c_fp;
        if (commit) begin
          rd_q   <= c_rd;
          data_q <= c_data;
        end
      end
    end
  end

  assign WE_reg         = we_reg_q;
  assign WE_freg        = we_freg_q;
  assign rd_addr_ex     = rd_q;
  assign reg_write_data = data_q;
  assign busy_int       = busy_int_q;
  assign busy_fp        = busy_fp_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a queue-based
// behavioural model of the commit stage.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Stall;
  logic        issue_valid, issue_fp;
  logic [4:0]  issue_rd;
  logic        alu_valid, alu_fp;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid, mem_fp;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        WE_reg, WE_freg;
  logic [4:0]  rd_addr_ex;
  logic [31:0] reg_write_data, busy_int, busy_fp;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall(Stall),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fp(issue_fp),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_fp(alu_fp),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_fp(mem_fp),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .WE_reg(WE_reg), .WE_freg(WE_freg), .rd_addr_ex(rd_addr_ex),
    .reg_write_data(reg_write_data), .busy_int(busy_int),
    .busy_fp(busy_fp), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: a queue of pending loads, two busy vectors and
  // the expected write-port contents.
  // ------------------------------------------------------------------
  typedef struct packed {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_bint, m_bfp;
  logic        m_we_reg, m_we_freg;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  ent_t        m_e;
  bit          m_c, m_full;

  initial begin
    m_bint = '0; m_bfp = '0; m_we_reg = 0; m_we_freg = 0; m_rd = '0; m_data = '0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_q.delete();
        m_bint = '0; m_bfp = '0; m_we_reg = 0; m_we_freg = 0;
        m_rd = '0; m_data = '0;
      end else begin
        m_full = (m_q.size() == DEPTH);
        m_c    = 0;
        m_e    = '0;
        if (!Stall) begin
          if (alu_valid) begin
            m_c = 1; m_e = '{alu_fp, alu_rd, alu_data};
          end else if (m_q.size() != 0) begin
            m_c = 1; m_e = m_q.pop_front();
          end
          m_we_freg = m_c && m_e.fp;
          m_we_reg  = m_c && !m_e.fp && (m_e.rd != 0);
          if (m_c) begin
            m_rd = m_e.rd; m_data = m_e.data;
            if (m_e.fp) m_bfp[m_e.rd] = 0; else m_bint[m_e.rd] = 0;
          end
        end
        if (mem_valid && !m_full) m_q.push_back('{mem_fp, mem_rd, mem_data});
        if (issue_valid) begin
          if (issue_fp) m_bfp[issue_rd] = 1; else m_bint[issue_rd] = 1;
        end
        m_bint[0] = 0;
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      check("we_reg",    WE_reg,         m_we_reg);
      check("we_freg",   WE_freg,        m_we_freg);
      check("rd_addr",   rd_addr_ex,     m_rd);
      check("wdata",     reg_write_data, m_data);
      check("busy_int",  busy_int,       m_bint);
      check("busy_fp",   busy_fp,        m_bfp);
      check("count",     fifo_count,     m_q.size());
      check("mem_ready", mem_ready,      m_q.size() != DEPTH);
      check("alu_ready", alu_ready,      alu_valid && !Stall);
    end
  end

  task automatic idle();
    Stall = 0; issue_valid = 0; issue_rd = 0; issue_fp = 0;
    alu_valid = 0; alu_rd = 0; alu_fp = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_fp = 0; mem_data = 0;
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 0;
    idle();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_we_reg", WE_reg, 0);
    check("rst_we_freg", WE_freg, 0);
    check("rst_rd", rd_addr_ex, 0);
    check("rst_data", reg_write_data, 0);
    check("rst_busy", busy_int | busy_fp, 0);
    check("rst_count", fifo_count, 0);
    #1 RST_N = 1;

    // First commit right after reset release.
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA5;
    tick(); idle();
    check("first_commit_we", WE_reg, 1);
    check("first_commit_rd", rd_addr_ex, 3);

    // ALU only.
    issue_valid = 1; issue_rd = 5;
    tick(); idle();
    check("busy5_set", busy_int[5], 1);
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1 check("alu_ready_1", alu_ready, 1);
    tick(); idle();
    check("alu_we", WE_reg, 1);
    check("alu_rd", rd_addr_ex, 5);
    check("alu_data", reg_write_data, 32'h1234);
    check("busy5_clr", busy_int[5], 0);
    tick();
    check("nocommit_we", WE_reg, 0);
    check("nocommit_hold_rd", rd_addr_ex, 5);
    check("nocommit_hold_data", reg_write_data, 32'h1234);

    // Conflict: ALU rd 6 vs FIFO head rd 7.
    mem_valid = 1; mem_rd = 7; mem_data = 32'h7777;
    tick(); idle();
    check("conf_count1", fifo_count, 1);
    alu_valid = 1; alu_rd = 6; alu_data = 32'h6666;
    tick(); idle();
    check("conf_first", rd_addr_ex, 6);
    check("conf_count_hold", fifo_count, 1);
    tick();
    check("conf_second", rd_addr_ex, 7);
    check("conf_second_data", reg_write_data, 32'h7777);
    check("conf_count0", fifo_count, 0);

    // Full FIFO while the ALU holds the slot.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 20; alu_data = i;
      mem_valid = 1; mem_rd = 5'(10 + i); mem_data = 32'h100 + i;
      tick();
    end
    idle();
    #1;
    check("full_count", fifo_count, 4);
    check("full_ready", mem_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_rd", rd_addr_ex, 10 + i);
      check("drain_data", reg_write_data, 32'h100 + i);
      check("drain_we", WE_reg, 1);
    end
    check("drain_count", fifo_count, 0);

    // Stall with a pending commit.
    alu_valid = 1; alu_rd = 15; alu_data = 32'h55;
    tick();
    check("stall_pending", WE_reg, 1);
    for (int k = 0; k < 3; k++) begin
      Stall = 1; alu_valid = 1; alu_rd = 16; alu_data = 32'h16;
      mem_valid = 1; mem_rd = 17; mem_data = 32'h70 + k;
      #1 check("stall_alu_ready", alu_ready, 0);
      tick();
      check("stall_hold_we", WE_reg, 1);
      check("stall_hold_rd", rd_addr_ex, 15);
      check("stall_push", fifo_count, k + 1);
    end
    idle();
    #1;
    check("stall_land_we", WE_reg, 1);
    check("stall_land_rd", rd_addr_ex, 15);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_drain_rd", rd_addr_ex, 17);
      check("stall_drain_data", reg_write_data, 32'h70 + k);
    end

    // x0 and FP destinations.
    issue_valid = 1; issue_rd = 0; issue_fp = 1;
    tick(); idle();
    check("busyfp0_set", busy_fp[0], 1);
    mem_valid = 1; mem_rd = 0; mem_fp = 0; mem_data = 32'hDEAD;
    tick(); idle();
    tick();
    check("x0_we_reg", WE_reg, 0);
    check("x0_we_freg", WE_freg, 0);
    check("x0_pop", fifo_count, 0);
    alu_valid = 1; alu_rd = 0; alu_fp = 1; alu_data = 32'h3F800000;
    tick(); idle();
    check("fp_we_freg", WE_freg, 1);
    check("fp_we_reg", WE_reg, 0);
    check("fp_data", reg_write_data, 32'h3F800000);
    check("busyfp0_clr", busy_fp[0], 0);

    // Set/clear race.
    issue_valid = 1; issue_rd = 9;
    tick();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
    tick(); idle();
    check("race_busy9", busy_int[9], 1);
    check("race_we", WE_reg, 1);

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 21; alu_data = 32'h21;
      mem_valid = 1; mem_rd = 5'(22 + i); mem_data = i;
      tick();
    end
    idle();
    tick();
    check("pre_rst_count", fifo_count, 2);
    #2 RST_N = 0;
    #1;
    check("arst_we", WE_reg, 0);
    check("arst_rd", rd_addr_ex, 0);
    check("arst_data", reg_write_data, 0);
    check("arst_busy", busy_int, 0);
    check("arst_count", fifo_count, 0);
    #3 RST_N = 1;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      Stall       = ($urandom_range(0, 4) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom);
      issue_fp    = $urandom_range(0, 1);
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_rd      = 5'($urandom);
      alu_fp      = $urandom_range(0, 1);
      alu_data    = $urandom;
      mem_valid   = $urandom_range(0, 1);
      mem_rd      = 5'($urandom);
      mem_fp      = $urandom_range(0, 1);
      mem_data    = $urandom;
      tick();
    end
    idle();
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 4, the load-result FIFO entry count (power of two, at least 2).

Interface
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- Stall  in  1  pipeline stall; no commit while high.
- issue_valid  in  1  instruction issued with destination.
- issue_rd  in  5  issued destination.
- issue_fp  in  1  destination is FP file.
- alu_valid  in  1  ALU/FPU result present.
- alu_rd  in  5  ALU destination.
- alu_fp  in  1  ALU destination FP.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid  in  1  load result present.
- mem_rd  in  5  load destination.
- mem_fp  in  1  load destination FP.
- mem_data  in  32  load data.
- mem_ready  out  1  FIFO not full.
- WE_reg  out  1  integer write enable to register file.
- WE_freg  out  1  FP write enable to register file.
- rd_addr_ex  out  5  write address.
- reg_write_data  out  32  write data.
- busy_int  out  32  integer pending-write mask.
- busy_fp  out  32  FP pending-write mask.
- fifo_count  out  3  FIFO occupancy, 0..DEPTH.

Function
REQ-003 A load SHALL be pushed into the FIFO when mem_valid && mem_ready; mem_ready SHALL be (fifo_count != DEPTH), combinational.
REQ-004 A commit slot SHALL be offered each cycle with Stall=0.
- An ALU result has priority: alu_ready = alu_valid && ~Stall.
- Otherwise the FIFO head commits if fifo_count != 0.
REQ-005 The committed source SHALL be registered into the output stage, so a commit appears on WE_reg/WE_freg/rd_addr_ex/reg_write_data exactly one cycle after acceptance.
REQ-006 Output enables SHALL follow the committed destination:
- WE_freg = 1 when fp = 1.
- WE_reg = 1 when fp = 0 and rd != 0.
- When fp = 0 and rd = 0, both enables SHALL be 0 while the commit is still consumed.
REQ-007 In a cycle with no commit, WE_reg and WE_freg SHALL be 0; rd_addr_ex and reg_write_data SHALL hold their previous values.
REQ-008 While Stall = 1, the output stage SHALL hold all values, including a pending enable, so the write lands on the first cycle after Stall falls.
- No ALU accept and no FIFO pop SHALL occur while Stall = 1.
- FIFO pushes SHALL continue.
REQ-009 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
- A push when full is impossible, because mem_ready is 0.
- A pop when empty SHALL not occur.
- Pointers SHALL wrap modulo DEPTH.
REQ-010 Scoreboard set and clear rules:
- issue_valid SHALL set busy_int[issue_rd] (fp = 0, rd != 0) or busy_fp[issue_rd] (fp = 1) at the next edge.
- A commit SHALL clear the matching bit when accepted.
- busy_int[0] SHALL be constant 0.
REQ-011 If a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-012 Commits SHALL be in-order within each source; the block SHALL NOT reorder FIFO entries.

Reset
REQ-013 While RST_N = 0, the following SHALL be 0: WE_reg, WE_freg, rd_addr_ex, reg_write_data, busy_int, busy_fp, fifo_count, and the FIFO pointers.
- Reset SHALL discard in-flight FIFO entries and any pending output.
REQ-014 The first commit SHALL be possible in the first cycle after RST_N rises.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- ALU only: alu_valid, rd = 5, fp = 0, data 0x1234 -> next cycle WE_reg = 1, rd_addr_ex = 5, reg_write_data = 0x1234; busy_int[5] cleared.
- Conflict: ALU (rd = 6) and FIFO head (rd = 7) both ready -> rd 6 committed first, rd 7 the following cycle; fifo_count 1 -> 0.
- Full FIFO: 4 loads pushed with ALU busy every cycle -> mem_ready = 0 and fifo_count = 4; after ALU stops, 4 consecutive commits in push order.
- Stall: a commit is pending when Stall goes high for 3 cycles -> outputs held; write lands the cycle Stall = 0; alu_ready = 0 throughout; pushes still counted.
- x0 and FP: commit rd = 0 fp = 0 -> no enables, FIFO pops; commit rd = 0 fp = 1 data 0x3F800000 -> WE_freg = 1.
- Set/clear race and reset: issue rd = 9 in the same cycle rd 9 commits -> busy_int[9] = 1; RST_N low mid-drain -> all outputs 0 and fifo_count = 0 immediately (asynchronous).
